// File: rtl/shunt_fringe_pkg.sv
// Shared types for the fringe endpoint: packet header, registration states, entry states.
package shunt_fringe_pkg;

  typedef enum logic [1:0] {
    PKT_REG  = 2'd0,
    PKT_ACK  = 2'd1,
    PKT_DATA = 2'd2,
    PKT_RSVD = 2'd3
  } pkt_type_e;

  typedef struct packed {
    pkt_type_e   ptype;
    logic [15:0] simid;
    logic [7:0]  idx;
  } fringe_pkt_t;

  localparam int HDR_W = $bits(fringe_pkt_t);
  localparam int DEF_DATA_W = 9;
  localparam int PKT_W = HDR_W + DEF_DATA_W;

  typedef enum logic [2:0] {
    R_IDLE,
    R_SEL,
    R_SEND,
    R_WAIT,
    R_DONE,
    R_ERR
  } reg_state_e;

  typedef enum logic {
    E_IDLE,
    E_ACTIVE
  } entry_state_e;

endpackage

// File: rtl/shunt_fringe_db.sv
// Per-signal payload store with valid flags; a write and a clear to the same
// index in one cycle leaves the entry valid. Payload survives a clear.
module shunt_fringe_db
  import shunt_fringe_pkg::*;
#(
  parameter int N  = 10,
  parameter int DW = 9,
  localparam int IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          clr_i,
  input  logic [IW-1:0] caddr_i,
  input  logic [IW-1:0] raddr_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic [N-1:0]  valid_q;
  logic [DW-1:0] mem_q [N];
  logic          rd_ok;

  // Clear first, then write, so a colliding write wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      if (clr_i && (32'(caddr_i) < 32'(N))) valid_q[caddr_i] <= 1'b0;
      if (we_i) begin
        valid_q[waddr_i] <= 1'b1;
        mem_q[waddr_i]   <= wdata_i;
      end
    end
  end

  assign rd_ok   = 32'(raddr_i) < 32'(N);
  assign valid_o = rd_ok ? valid_q[raddr_i] : 1'b0;
  assign data_o  = rd_ok ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/shunt_fringe.sv
// Fringe endpoint: registers remote target entries, then exports put data and
// buffers received DATA packets in the payload DB.
module shunt_fringe
  import shunt_fringe_pkg::*;
#(
  parameter int          N_SIGNALS = 10,
  parameter int          N_TARGETS = 1,
  parameter int          DATA_W    = 9,
  parameter logic [15:0] SIM_ID    = 16'd0,
  parameter bit          IS_INIT   = 1'b1,
  localparam int IW = $clog2(N_SIGNALS),
  localparam int PW = HDR_W + DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              reg_start_i,
  output logic              reg_done_o,
  output logic              reg_err_o,
  input  logic              put_req_i,
  input  logic [IW-1:0]     put_idx_i,
  input  logic [DATA_W-1:0] put_data_i,
  output logic              put_ack_o,
  output logic              put_err_o,
  input  logic [IW-1:0]     get_idx_i,
  output logic              get_valid_o,
  output logic [DATA_W-1:0] get_data_o,
  input  logic              get_clr_i,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [PW-1:0]     tx_pkt_o,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  input  logic [PW-1:0]     rx_pkt_i
);

  reg_state_e        reg_state_q;
  entry_state_e      entry_q [N_TARGETS];
  logic              reg_done_q, reg_err_q, rdy_q, put_err_q, put_err_d;
  logic [7:0]        sel_q, sel_idx, ack_idx_q, data_idx_q;
  logic              tx_valid_q, ack_pend_q, data_pend_q;
  logic [PW-1:0]     tx_pkt_q;
  logic [DATA_W-1:0] data_q;
  logic              have_idle, all_active;
  logic              rx_fire, tx_fire, ack_busy, put_idx_ok, db_we;
  fringe_pkt_t       rx_hdr, tx_hdr;
  logic [DATA_W-1:0] rx_pay;
  logic              unused_hdr;

  assign rx_hdr     = rx_pkt_i[PW-1:DATA_W];
  assign rx_pay     = rx_pkt_i[DATA_W-1:0];
  assign tx_hdr     = tx_pkt_q[PW-1:DATA_W];
  assign unused_hdr = ^{rx_hdr.simid, tx_hdr.simid};

  assign tx_fire    = tx_valid_q & tx_ready_i;
  // An ACK waiting to be loaded or sitting in tx blocks further REG intake.
  assign ack_busy   = ack_pend_q | (tx_valid_q & (tx_hdr.ptype == PKT_ACK));
  assign rx_ready_o = rdy_q & ~ack_busy;
  assign rx_fire    = rx_valid_i & rx_ready_o;
  assign put_idx_ok = 32'(put_idx_i) < 32'(N_SIGNALS);
  assign put_err_d  = put_req_i & (~reg_done_q | ~put_idx_ok);
  assign db_we      = rx_fire & (rx_hdr.ptype == PKT_DATA) &
                      (32'(rx_hdr.idx) < 32'(N_SIGNALS));

  assign put_ack_o  = tx_fire & (tx_hdr.ptype == PKT_DATA);
  assign put_err_o  = put_err_q;
  assign reg_done_o = reg_done_q;
  assign reg_err_o  = reg_err_q;
  assign tx_valid_o = tx_valid_q;
  assign tx_pkt_o   = tx_pkt_q;

  // Lowest IDLE entry, and whether every entry is ACTIVE.
  always_comb begin
    have_idle  = 1'b0;
    all_active = 1'b1;
    sel_idx    = '0;
    for (int i = N_TARGETS - 1; i >= 0; i--) begin
      if (entry_q[i] == E_IDLE) begin
        have_idle  = 1'b1;
        all_active = 1'b0;
        sel_idx    = 8'(i);
      end
    end
  end

  // Registration FSM, put capture and the single-slot tx register.
  // The tx slot only reloads when empty, so its packet never changes while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_state_q <= R_IDLE;
      reg_done_q  <= 1'b0;
      reg_err_q   <= 1'b0;
      sel_q       <= '0;
      rdy_q       <= 1'b0;
      put_err_q   <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_pkt_q    <= '0;
      ack_pend_q  <= 1'b0;
      ack_idx_q   <= '0;
      data_pend_q <= 1'b0;
      data_idx_q  <= '0;
      data_q      <= '0;
      for (int i = 0; i < N_TARGETS; i++) entry_q[i] <= E_IDLE;
    end else begin
      rdy_q     <= 1'b1;
      put_err_q <= put_err_d;

      // put_req_i is a pulse; one request is buffered until it reaches tx.
      if (put_req_i && !put_err_d && !data_pend_q) begin
        data_pend_q <= 1'b1;
        data_idx_q  <= 8'(put_idx_i);
        data_q      <= put_data_i;
      end

      if (!IS_INIT) begin
        if (rx_fire && rx_hdr.ptype == PKT_REG) begin
          ack_pend_q <= 1'b1;
          ack_idx_q  <= rx_hdr.idx;
        end
        if (tx_fire && tx_hdr.ptype == PKT_ACK) begin
          for (int i = 0; i < N_TARGETS; i++)
            if (tx_hdr.idx == 8'(i)) entry_q[i] <= E_ACTIVE;
        end
        if (all_active) reg_done_q <= 1'b1;
      end

      case (reg_state_q)
        R_IDLE: if (IS_INIT && reg_start_i) reg_state_q <= R_SEL;
        R_SEL: begin
          if (!have_idle) begin
            reg_state_q <= R_DONE;
            reg_done_q  <= 1'b1;
          end
        end
        R_SEND: if (tx_fire) reg_state_q <= R_WAIT;
        R_WAIT: begin
          if (rx_fire && rx_hdr.ptype == PKT_ACK) begin
            if (rx_hdr.idx == sel_q) begin
              for (int i = 0; i < N_TARGETS; i++)
                if (sel_q == 8'(i)) entry_q[i] <= E_ACTIVE;
              reg_state_q <= R_SEL;
            end else begin
              reg_err_q   <= 1'b1;
              reg_state_q <= R_ERR;
            end
          end
        end
        default: reg_state_q <= reg_state_q;
      endcase

      if (tx_fire) begin
        tx_valid_q <= 1'b0;
      end else if (!tx_valid_q) begin
        if (ack_pend_q) begin
          tx_valid_q <= 1'b1;
          tx_pkt_q   <= {PKT_ACK, SIM_ID, ack_idx_q, {DATA_W{1'b0}}};
          ack_pend_q <= 1'b0;
        end else if (reg_state_q == R_SEL && have_idle) begin
          tx_valid_q  <= 1'b1;
          tx_pkt_q    <= {PKT_REG, SIM_ID, sel_idx, {DATA_W{1'b0}}};
          sel_q       <= sel_idx;
          reg_state_q <= R_SEND;
        end else if (data_pend_q) begin
          tx_valid_q  <= 1'b1;
          tx_pkt_q    <= {PKT_DATA, SIM_ID, data_idx_q, data_q};
          data_pend_q <= 1'b0;
        end
      end
    end
  end

  shunt_fringe_db #(
    .N  (N_SIGNALS),
    .DW (DATA_W)
  ) u_db (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (db_we),
    .waddr_i (rx_hdr.idx[IW-1:0]),
    .wdata_i (rx_pay),
    .clr_i   (get_clr_i),
    .caddr_i (get_idx_i),
    .raddr_i (get_idx_i),
    .valid_o (get_valid_o),
    .data_o  (get_data_o)
  );

endmodule

// File: tb/tb_shunt_fringe.sv
// Self-checking bench for shunt_fringe as an initiator with two target entries.
module tb_shunt_fringe;

  localparam int NS = 10;
  localparam int DW = 9;
  localparam int PW = 35;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          reg_start_i = 1'b0;
  logic          reg_done_o, reg_err_o;
  logic          put_req_i = 1'b0;
  logic [3:0]    put_idx_i = '0;
  logic [DW-1:0] put_data_i = '0;
  logic          put_ack_o, put_err_o;
  logic [3:0]    get_idx_i = '0;
  logic          get_valid_o;
  logic [DW-1:0] get_data_o;
  logic          get_clr_i = 1'b0;
  logic          tx_valid_o;
  logic          tx_ready_i = 1'b0;
  logic [PW-1:0] tx_pkt_o;
  logic          rx_valid_i = 1'b0;
  logic          rx_ready_o;
  logic [PW-1:0] rx_pkt_i = '0;

  int n_checks = 0;
  int n_fail = 0;

  // reference DB model
  bit            m_val [NS];
  logic [DW-1:0] m_dat [NS];

  shunt_fringe #(
    .N_SIGNALS (NS),
    .N_TARGETS (2),
    .DATA_W    (DW),
    .SIM_ID    (16'd0),
    .IS_INIT   (1'b1)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .reg_start_i (reg_start_i),
    .reg_done_o  (reg_done_o),
    .reg_err_o   (reg_err_o),
    .put_req_i   (put_req_i),
    .put_idx_i   (put_idx_i),
    .put_data_i  (put_data_i),
    .put_ack_o   (put_ack_o),
    .put_err_o   (put_err_o),
    .get_idx_i   (get_idx_i),
    .get_valid_o (get_valid_o),
    .get_data_o  (get_data_o),
    .get_clr_i   (get_clr_i),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .tx_pkt_o    (tx_pkt_o),
    .rx_valid_i  (rx_valid_i),
    .rx_ready_o  (rx_ready_o),
    .rx_pkt_i    (rx_pkt_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [PW-1:0] mk(input logic [1:0] t, input logic [7:0] idx,
                                       input logic [DW-1:0] d);
    return {t, 16'h0000, idx, d};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_tx(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (tx_valid_o === 1'b1) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic idle_inputs();
    reg_start_i = 0; put_req_i = 0; put_idx_i = '0; put_data_i = '0;
    get_idx_i = '0; get_clr_i = 0; tx_ready_i = 0; rx_valid_i = 0; rx_pkt_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 0;
    tick(); tick();
    rst_ni = 1;
    tick();
    for (int i = 0; i < NS; i++) begin m_val[i] = 0; m_dat[i] = '0; end
  endtask

  task automatic do_register();
    bit seen;
    reg_start_i = 1; tick(); reg_start_i = 0;
    for (int k = 0; k < 2; k++) begin
      wait_tx(seen);
      n_checks++;
      if (!seen || tx_pkt_o !== mk(2'd0, 8'(k), '0)) begin
        n_fail++;
        $display("FAIL reg_send_%0d: got valid=%b pkt=%h expected pkt=%h", k, tx_valid_o, tx_pkt_o, mk(2'd0, 8'(k), '0));
      end
      tx_ready_i = 1; tick(); tx_ready_i = 0;
      rx_valid_i = 1; rx_pkt_i = mk(2'd1, 8'(k), '0);
      n_checks++;
      if (rx_ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL rx_ready_ack_%0d: got %b expected 1", k, rx_ready_o);
      end
      tick(); rx_valid_i = 0;
    end
    for (int k = 0; k < 10 && reg_done_o !== 1'b1; k++) tick();
    n_checks++;
    if (reg_done_o !== 1'b1 || reg_err_o !== 1'b0 || tx_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_done: got done=%b err=%b txv=%b expected 1 0 0", reg_done_o, reg_err_o, tx_valid_o);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 0;
    tick();
    n_checks++;
    if ({reg_done_o, reg_err_o, put_ack_o, put_err_o, tx_valid_o, rx_ready_o, get_valid_o} !== 7'b0
        || tx_pkt_o !== '0 || get_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got done=%b err=%b ack=%b perr=%b txv=%b rxr=%b gv=%b pkt=%h gd=%h expected all 0",
               reg_done_o, reg_err_o, put_ack_o, put_err_o, tx_valid_o, rx_ready_o, get_valid_o, tx_pkt_o, get_data_o);
    end
    rst_ni = 1; tick();
    n_checks++;
    if (rx_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_ready_after_reset: got %b expected 1", rx_ready_o);
    end
    put_req_i = 1; put_idx_i = 4'd3; put_data_i = 9'h011; tick(); put_req_i = 0;
    n_checks++;
    if (put_err_o !== 1'b1 || tx_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL put_before_reg: got perr=%b txv=%b expected 1 0", put_err_o, tx_valid_o);
    end
    tick();
    n_checks++;
    if (put_err_o !== 1'b0 || tx_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL put_err_pulse: got perr=%b txv=%b expected 0 0", put_err_o, tx_valid_o);
    end
  endtask

  task automatic test_registration();
    do_reset();
    do_register();
    reg_start_i = 1; tick(); reg_start_i = 0;
    begin
      bit any_tx = 0;
      for (int k = 0; k < 5; k++) begin if (tx_valid_o === 1'b1) any_tx = 1; tick(); end
      n_checks++;
      if (any_tx || reg_done_o !== 1'b1) begin
        n_fail++;
        $display("FAIL reg_start_ignored: got tx=%b done=%b expected 0 1", any_tx, reg_done_o);
      end
    end
  endtask

  task automatic test_reg_error();
    bit seen;
    bit any_tx = 0;
    do_reset();
    reg_start_i = 1; tick(); reg_start_i = 0;
    wait_tx(seen);
    n_checks++;
    if (!seen || tx_pkt_o !== mk(2'd0, 8'd0, '0)) begin
      n_fail++;
      $display("FAIL err_reg0: got valid=%b pkt=%h expected %h", tx_valid_o, tx_pkt_o, mk(2'd0, 8'd0, '0));
    end
    tx_ready_i = 1; tick(); tx_ready_i = 0;
    rx_valid_i = 1; rx_pkt_i = mk(2'd1, 8'd1, '0); tick(); rx_valid_i = 0;
    n_checks++;
    if (reg_err_o !== 1'b1 || reg_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_err: got err=%b done=%b expected 1 0", reg_err_o, reg_done_o);
    end
    tx_ready_i = 1;
    for (int k = 0; k < 10; k++) begin if (tx_valid_o === 1'b1) any_tx = 1; tick(); end
    tx_ready_i = 0;
    n_checks++;
    if (any_tx || reg_err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reg_err_terminal: got tx=%b err=%b expected 0 1", any_tx, reg_err_o);
    end
  endtask

  task automatic test_put();
    bit seen;
    int acks = 0;
    bit held_ok = 1;
    logic [PW-1:0] exp_pkt;
    do_reset();
    do_register();
    exp_pkt = mk(2'd2, 8'd3, 9'h1A5);
    put_req_i = 1; put_idx_i = 4'd3; put_data_i = 9'h1A5; tick(); put_req_i = 0;
    put_data_i = 9'h000;
    wait_tx(seen);
    for (int k = 0; k < 3; k++) begin
      if (tx_valid_o !== 1'b1 || tx_pkt_o !== exp_pkt) held_ok = 0;
      if (put_ack_o === 1'b1) acks++;
      tick();
    end
    n_checks++;
    if (!seen || !held_ok) begin
      n_fail++;
      $display("FAIL put_hold: got valid=%b pkt=%h expected pkt=%h held", tx_valid_o, tx_pkt_o, exp_pkt);
    end
    tx_ready_i = 1; #1;
    n_checks++;
    if (put_ack_o !== 1'b1 || tx_pkt_o !== exp_pkt) begin
      n_fail++;
      $display("FAIL put_xfer: got ack=%b pkt=%h expected 1 %h", put_ack_o, tx_pkt_o, exp_pkt);
    end
    if (put_ack_o === 1'b1) acks++;
    tick(); tx_ready_i = 0;
    for (int k = 0; k < 4; k++) begin
      if (put_ack_o === 1'b1 || tx_valid_o === 1'b1) acks++;
      tick();
    end
    n_checks++;
    if (acks != 1) begin
      n_fail++;
      $display("FAIL put_ack_once: got %0d pulses expected 1", acks);
    end
    put_req_i = 1; put_idx_i = 4'd12; put_data_i = 9'h0AA; tick(); put_req_i = 0;
    n_checks++;
    if (put_err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL put_idx12_err: got %b expected 1", put_err_o);
    end
    tx_ready_i = 1; tick();
    n_checks++;
    if (put_err_o !== 1'b0 || tx_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL put_idx12_nosend: got perr=%b txv=%b expected 0 0", put_err_o, tx_valid_o);
    end
    tx_ready_i = 0;
  endtask

  task automatic test_put_random();
    bit seen;
    for (int it = 0; it < 12; it++) begin
      int idx = $urandom_range(0, 15);
      logic [DW-1:0] d = DW'($urandom_range(0, 511));
      int stall = $urandom_range(0, 3);
      put_req_i = 1; put_idx_i = 4'(idx); put_data_i = d; tick(); put_req_i = 0;
      if (idx < NS) begin
        n_checks++;
        if (put_err_o !== 1'b0) begin
          n_fail++;
          $display("FAIL rput_err_%0d: got perr=1 expected 0 for idx %0d", it, idx);
        end
        wait_tx(seen);
        repeat (stall) tick();
        tx_ready_i = 1; #1;
        n_checks++;
        if (!seen || put_ack_o !== 1'b1 || tx_pkt_o !== mk(2'd2, 8'(idx), d)) begin
          n_fail++;
          $display("FAIL rput_pkt_%0d: got ack=%b pkt=%h expected 1 %h", it, put_ack_o, tx_pkt_o, mk(2'd2, 8'(idx), d));
        end
        tick(); tx_ready_i = 0;
      end else begin
        n_checks++;
        if (put_err_o !== 1'b1) begin
          n_fail++;
          $display("FAIL rput_oob_%0d: got perr=%b expected 1 for idx %0d", it, put_err_o, idx);
        end
        tick();
        n_checks++;
        if (tx_valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL rput_oob_tx_%0d: got txv=%b expected 0", it, tx_valid_o);
        end
      end
    end
  endtask

  task automatic test_get();
    get_idx_i = 4'd0; #1;
    n_checks++;
    if (get_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL get_pre: got %b expected 0", get_valid_o);
    end
    rx_valid_i = 1; rx_pkt_i = mk(2'd2, 8'd0, 9'h155); tick(); rx_valid_i = 0;
    n_checks++;
    if (get_valid_o !== 1'b1 || get_data_o !== 9'h155) begin
      n_fail++;
      $display("FAIL get_write: got v=%b d=%h expected 1 155", get_valid_o, get_data_o);
    end
    get_clr_i = 1; tick(); get_clr_i = 0;
    n_checks++;
    if (get_valid_o !== 1'b0 || get_data_o !== 9'h155) begin
      n_fail++;
      $display("FAIL get_clear: got v=%b d=%h expected 0 155", get_valid_o, get_data_o);
    end
  endtask

  task automatic test_collision();
    rx_valid_i = 1; rx_pkt_i = mk(2'd2, 8'd2, 9'h033); tick(); rx_valid_i = 0;
    get_idx_i = 4'd2; get_clr_i = 1;
    rx_valid_i = 1; rx_pkt_i = mk(2'd2, 8'd2, 9'h0FF); tick();
    rx_valid_i = 0; get_clr_i = 0; #1;
    n_checks++;
    if (get_valid_o !== 1'b1 || get_data_o !== 9'h0FF) begin
      n_fail++;
      $display("FAIL collision: got v=%b d=%h expected 1 0ff", get_valid_o, get_data_o);
    end
  endtask

  task automatic test_get_random();
    do_reset();
    do_register();
    for (int it = 0; it < 150; it++) begin
      bit rv = ($urandom_range(0, 3) != 0);
      int t = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : 2;
      int idx = $urandom_range(0, 13);
      logic [DW-1:0] d = DW'($urandom_range(0, 511));
      bit clr = ($urandom_range(0, 2) == 0);
      int cidx = $urandom_range(0, NS - 1);
      int gidx = $urandom_range(0, NS - 1);
      rx_valid_i = rv; rx_pkt_i = mk(2'(t), 8'(idx), d);
      get_clr_i = clr; get_idx_i = 4'(cidx);
      tick();
      if (clr) m_val[cidx] = 0;
      if (rv && t == 2 && idx < NS) begin m_val[idx] = 1; m_dat[idx] = d; end
      rx_valid_i = 0; get_clr_i = 0; get_idx_i = 4'(gidx); #1;
      n_checks++;
      if (get_valid_o !== m_val[gidx] || get_data_o !== m_dat[gidx]) begin
        n_fail++;
        $display("FAIL rget_%0d idx%0d: got v=%b d=%h expected %b %h", it, gidx, get_valid_o, get_data_o, m_val[gidx], m_dat[gidx]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit any_valid = 0;
    rx_valid_i = 1; rx_pkt_i = mk(2'd2, 8'd5, 9'h1C3); tick(); rx_valid_i = 0;
    put_req_i = 1; put_idx_i = 4'd4; put_data_i = 9'h077; tick(); put_req_i = 0;
    wait_tx(seen);
    #3; rst_ni = 0; #1;
    n_checks++;
    if ({reg_done_o, reg_err_o, put_ack_o, put_err_o, tx_valid_o, rx_ready_o} !== 6'b0 || tx_pkt_o !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got done=%b err=%b ack=%b perr=%b txv=%b rxr=%b pkt=%h expected 0",
               reg_done_o, reg_err_o, put_ack_o, put_err_o, tx_valid_o, rx_ready_o, tx_pkt_o);
    end
    for (int i = 0; i < NS; i++) begin
      get_idx_i = 4'(i); #1;
      if (get_valid_o !== 1'b0 || get_data_o !== '0) any_valid = 1;
    end
    n_checks++;
    if (!seen || any_valid) begin
      n_fail++;
      $display("FAIL mid_reset_db: got tx_seen=%b stale=%b expected 1 0", seen, any_valid);
    end
    tick(); rst_ni = 1; tick();
    put_req_i = 1; put_idx_i = 4'd4; tick(); put_req_i = 0;
    n_checks++;
    if (put_err_o !== 1'b1 || tx_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_put: got perr=%b txv=%b expected 1 0", put_err_o, tx_valid_o);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_registration();
    test_reg_error();
    test_put();
    test_put_random();
    test_get();
    test_collision();
    test_get_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
